// File: rtl/uart_ctrl_pkg.sv
// Shared types and constant helpers for the UART transmit scheduling blocks.
package uart_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_GAP       = 3'd4
   } sched_state_e;

   // Smallest r with 2**r >= value; 0 for value <= 1.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational one-hot round-robin picker, searching upward from last_grant_i+1 with wrap.
module rr_arbiter
   import uart_ctrl_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic [$clog2(NUM_REQ)-1:0] last_grant_i,
   output logic [NUM_REQ-1:0]         grant_o,
   output logic [$clog2(NUM_REQ)-1:0] grant_idx_o,
   output logic                       any_o
);

   localparam int IDX_W = clog2(NUM_REQ);

   always_comb begin
      logic found;
      int   idx;
      grant_o     = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      idx         = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last_grant_i) + k) % NUM_REQ;
         if (!found && req_i[idx]) begin
            found        = 1'b1;
            grant_o[idx] = 1'b1;
            grant_idx_o  = IDX_W'(idx);
         end
      end
   end

   assign any_o = |req_i;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ byte producers with round-robin grants,
// start-timeout detection and an enforced idle gap between frames.
module uart_tx_scheduler
   import uart_ctrl_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int DATA_WIDTH    = 8,
   parameter int GAP_CYCLES    = 16,
   parameter int START_TIMEOUT = 8
) (
   input  logic                          clk_i,
   input  logic                          reset_n_i,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   output logic                          tx_start_o,
   output logic [DATA_WIDTH-1:0]         tx_data_o,
   input  logic                          tx_busy_i,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id_o,
   output logic                          active_o,
   output logic                          timeout_err_o
);

   localparam int IDX_W     = clog2(NUM_REQ);
   localparam int CNT_MAX_I = max2(GAP_CYCLES, START_TIMEOUT);
   localparam int CNT_W     = clog2(CNT_MAX_I + 1);

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CNT_MAX_I);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(START_TIMEOUT - 1);
   localparam logic             TO_IMMEDIATE = (START_TIMEOUT == 1);

   sched_state_e          state_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [CNT_W-1:0]      cnt_d;
   logic [IDX_W-1:0]      last_grant_q;
   logic [DATA_WIDTH-1:0] tx_data_q;
   logic [IDX_W-1:0]      grant_id_q;
   logic                  tx_start_q;
   logic                  active_q;
   logic                  timeout_err_q;

   logic [NUM_REQ-1:0]    pick_onehot;
   logic [IDX_W-1:0]      pick_idx;
   logic                  any_valid;
   logic                  can_grant;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arbiter (
      .req_i        (req_valid_i),
      .last_grant_i (last_grant_q),
      .grant_o      (pick_onehot),
      .grant_idx_o  (pick_idx),
      .any_o        (any_valid)
   );

   assign can_grant   = (state_q == ST_IDLE) && !tx_busy_i && any_valid;
   assign req_ready_o = can_grant ? pick_onehot : '0;
   assign cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

   // timeout_err is raised one cycle ahead so the registered pulse lands on the
   // final WAIT_BUSY cycle, which then hands over to GAP unconditionally.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         last_grant_q  <= IDX_W'(NUM_REQ - 1);
         tx_data_q     <= '0;
         grant_id_q    <= '0;
         tx_start_q    <= 1'b0;
         active_q      <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         tx_start_q    <= 1'b0;
         timeout_err_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (can_grant) begin
                  tx_data_q    <= req_data_i[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
                  last_grant_q <= pick_idx;
                  grant_id_q   <= pick_idx;
                  tx_start_q   <= 1'b1;
                  active_q     <= 1'b1;
                  state_q      <= ST_START;
               end
            end
            ST_START: begin
               cnt_q         <= '0;
               timeout_err_q <= TO_IMMEDIATE && !tx_busy_i;
               state_q       <= ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
               if (timeout_err_q) begin
                  cnt_q   <= '0;
                  state_q <= ST_GAP;
               end else if (tx_busy_i) begin
                  state_q <= ST_WAIT_DONE;
               end else begin
                  cnt_q <= cnt_d;
                  if (cnt_d == TO_LAST) begin
                     timeout_err_q <= 1'b1;
                  end
               end
            end
            ST_WAIT_DONE: begin
               if (!tx_busy_i) begin
                  cnt_q   <= '0;
                  state_q <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (cnt_q == GAP_LAST) begin
                  cnt_q    <= '0;
                  active_q <= 1'b0;
                  state_q  <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            default: begin
               cnt_q    <= '0;
               active_q <= 1'b0;
               state_q  <= ST_IDLE;
            end
         endcase
      end
   end

   assign tx_start_o    = tx_start_q;
   assign tx_data_o     = tx_data_q;
   assign grant_id_o    = grant_id_q;
   assign active_o      = active_q;
   assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: a default-parameter instance plus a GAP_CYCLES=0 instance,
// each driven by a simple transmitter model that holds busy for BUSY_LEN cycles.
module tb_uart_tx_scheduler;

   localparam int NUM_REQ       = 4;
   localparam int DATA_WIDTH    = 8;
   localparam int GAP_CYCLES    = 16;
   localparam int START_TIMEOUT = 8;
   localparam int BUSY_LEN      = 10;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_busy;
   logic [1:0]  grant_id;
   logic        active;
   logic        timeout_err;

   logic [3:0]  req_valid_g0;
   logic [31:0] req_data_g0;
   logic [3:0]  req_ready_g0;
   logic        tx_start_g0;
   logic [7:0]  tx_data_g0;
   logic        tx_busy_g0;
   logic [1:0]  grant_id_g0;
   logic        active_g0;
   logic        timeout_err_g0;

   always #5 clk = ~clk;

   uart_tx_scheduler #(
      .NUM_REQ       (NUM_REQ),
      .DATA_WIDTH    (DATA_WIDTH),
      .GAP_CYCLES    (GAP_CYCLES),
      .START_TIMEOUT (START_TIMEOUT)
   ) dut (
      .clk_i         (clk),
      .reset_n_i     (reset_n),
      .req_valid_i   (req_valid),
      .req_data_i    (req_data),
      .req_ready_o   (req_ready),
      .tx_start_o    (tx_start),
      .tx_data_o     (tx_data),
      .tx_busy_i     (tx_busy),
      .grant_id_o    (grant_id),
      .active_o      (active),
      .timeout_err_o (timeout_err)
   );

   uart_tx_scheduler #(
      .NUM_REQ       (NUM_REQ),
      .DATA_WIDTH    (DATA_WIDTH),
      .GAP_CYCLES    (0),
      .START_TIMEOUT (START_TIMEOUT)
   ) dutGap0 (
      .clk_i         (clk),
      .reset_n_i     (reset_n),
      .req_valid_i   (req_valid_g0),
      .req_data_i    (req_data_g0),
      .req_ready_o   (req_ready_g0),
      .tx_start_o    (tx_start_g0),
      .tx_data_o     (tx_data_g0),
      .tx_busy_i     (tx_busy_g0),
      .grant_id_o    (grant_id_g0),
      .active_o      (active_g0),
      .timeout_err_o (timeout_err_g0)
   );

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic modelEn = 1'b1;
   logic forceBusy = 1'b0;
   int   busyCnt = 0;
   int   busyCntG0 = 0;

   // Transmitter models: busy rises the cycle after the start pulse and stays high BUSY_LEN cycles.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (modelEn && tx_start) busyCnt <= BUSY_LEN;
      else if (busyCnt > 0) busyCnt <= busyCnt - 1;
      if (tx_start_g0) busyCntG0 <= BUSY_LEN;
      else if (busyCntG0 > 0) busyCntG0 <= busyCntG0 - 1;
   end

   assign tx_busy    = forceBusy | (busyCnt > 0);
   assign tx_busy_g0 = (busyCntG0 > 0);

   typedef struct {
      logic [1:0] id;
      logic [7:0] data;
      int         acceptCyc;
   } exp_t;

   exp_t sb[$];

   typedef struct {
      logic [3:0]  valid;
      logic [31:0] data;
      logic [3:0]  expReady;
      logic [1:0]  expId;
      logic [7:0]  expData;
   } vec_t;

   vec_t vecs[7];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] data);
      @(posedge clk);
      #1;
      req_valid = valid;
      req_data  = data;
   endtask

   task automatic doReset();
      @(posedge clk);
      #1;
      reset_n      = 1'b0;
      req_valid    = '0;
      req_valid_g0 = '0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic acceptExpected(input string name, input logic [3:0] expReady,
                                 input logic [1:0] expId, input logic [7:0] expData,
                                 output int tCyc);
      tCyc = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (req_ready != 4'b0) begin
            tCyc = cyc;
            break;
         end
      end
      if (tCyc < 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s: req_ready never asserted, required 0x%0h", name, expReady);
      end else begin
         checkOutput(name, 32'(req_ready), 32'(expReady));
         sb.push_back('{expId, expData, tCyc});
      end
   endtask

   task automatic waitIdle(input string name);
      logic done;
      done = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 200; i++) begin
         if (!active) begin
            done = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!done) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s: active stuck at 1, required 0", name);
      end
   endtask

   // Every start pulse must carry the next expected grant, one cycle after its accept.
   always @(negedge clk) begin
      if (reset_n && tx_start) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected tx_start: got 1 required 0 at cycle %0d", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("start grant_id", 32'(grant_id), 32'(e.id));
            checkOutput("start tx_data", 32'(tx_data), 32'(e.data));
            checkOutput("start latency", 32'(cyc), 32'(e.acceptCyc + 1));
         end
      end
   end

   initial begin
      int t0;
      int t1;
      int toCount;
      int toFirst;
      int nextReady;
      logic sawEarly;
      logic [31:0] fairData;
      logic [1:0] order[6];

      vecs[0] = '{4'b0100, 32'h11A52233, 4'b0100, 2'd2, 8'hA5};
      vecs[1] = '{4'b1011, 32'h4C3B2A19, 4'b1000, 2'd3, 8'h4C};
      vecs[2] = '{4'b1011, 32'h5D6E7F80, 4'b0001, 2'd0, 8'h80};
      vecs[3] = '{4'b1010, 32'h01FE02FD, 4'b0010, 2'd1, 8'h02};
      vecs[4] = '{4'b0001, 32'h000000C3, 4'b0001, 2'd0, 8'hC3};
      vecs[5] = '{4'b1100, 32'h77665544, 4'b0100, 2'd2, 8'h66};
      vecs[6] = '{4'b0011, 32'h9A8B7C6D, 4'b0001, 2'd0, 8'h6D};
      order    = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      fairData = 32'hD4C3B2A1;

      reset_n      = 1'b0;
      req_valid    = '0;
      req_data     = '0;
      req_valid_g0 = '0;
      req_data_g0  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset req_ready", 32'(req_ready), 32'h0);
      checkOutput("reset outputs", {20'h0, tx_start, tx_data, grant_id, active, timeout_err}, 32'h0);
      checkOutput("reset outputs gap0", {16'h0, req_ready_g0, tx_start_g0, tx_data_g0, grant_id_g0,
                                         active_g0, timeout_err_g0}, 32'h0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      for (int v = 0; v < 7; v++) begin
         applyStimulus(vecs[v].valid, vecs[v].data);
         acceptExpected($sformatf("vec%0d req_ready", v), vecs[v].expReady, vecs[v].expId,
                        vecs[v].expData, t0);
         applyStimulus(4'b0, 32'h0);
         repeat (5) @(negedge clk);
         checkOutput($sformatf("vec%0d tx_data held", v), 32'(tx_data), 32'(vecs[v].expData));
         checkOutput($sformatf("vec%0d active/ready busy", v), {27'h0, active, req_ready}, 32'h10);
         waitIdle($sformatf("vec%0d idle", v));
      end

      doReset();
      applyStimulus(4'b1111, fairData);
      for (int g = 0; g < 6; g++) begin
         acceptExpected($sformatf("fair grant%0d", g), 4'(1 << order[g]), order[g],
                        fairData[int'(order[g])*8 +: 8], t1);
         if (g == 0) t0 = t1;
         if (g == 1) checkOutput("gap16 next ready", 32'(t1), 32'(t0 + 2 + BUSY_LEN + GAP_CYCLES + 1));
      end
      applyStimulus(4'b0, 32'h0);
      waitIdle("fair idle");

      doReset();
      req_valid_g0 = 4'b0001;
      req_data_g0  = 32'h0000003C;
      t0 = -1;
      t1 = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (t0 >= 0 && cyc == t0 + 1) begin
            checkOutput("gap0 tx_start", 32'(tx_start_g0), 32'h1);
            checkOutput("gap0 tx_data", 32'(tx_data_g0), 32'h3C);
         end
         if (req_ready_g0 != 4'b0) begin
            if (t0 < 0) t0 = cyc;
            else if (cyc > t0) begin
               t1 = cyc;
               break;
            end
         end
      end
      checkOutput("gap0 next ready", 32'(t1), 32'(t0 + 2 + BUSY_LEN + 2));
      @(posedge clk);
      #1;
      req_valid_g0 = 4'b0;

      doReset();
      modelEn = 1'b1;
      applyStimulus(4'b0001, 32'h000000E7);
      acceptExpected("midreset accept", 4'b0001, 2'd0, 8'hE7, t0);
      applyStimulus(4'b0, 32'h0);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n   = 1'b1;
      req_valid = 4'b1010;
      req_data  = 32'h11002200;
      @(negedge clk);
      checkOutput("midreset outputs", {20'h0, tx_start, tx_data, grant_id, active, timeout_err}, 32'h0);
      checkOutput("midreset ready busy", {27'h0, tx_busy, req_ready}, 32'h10);
      sawEarly = 1'b0;
      t1 = -1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (!tx_busy) begin
            t1 = cyc;
            break;
         end
         if (req_ready != 4'b0) sawEarly = 1'b1;
      end
      checkOutput("midreset no grant while busy", 32'(sawEarly), 32'h0);
      checkOutput("midreset busy release", 32'(t1 >= 0), 32'h1);
      checkOutput("midreset winner", 32'(req_ready), 32'h2);
      sb.push_back('{2'd1, 8'h22, cyc});
      applyStimulus(4'b0, 32'h0);
      repeat (15) @(negedge clk);
      @(posedge clk);
      #1;
      forceBusy = 1'b1;
      req_valid = 4'b0100;
      req_data  = 32'h00990000;
      waitIdle("busyidle reach idle");
      sawEarly = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (req_ready != 4'b0) sawEarly = 1'b1;
      end
      checkOutput("busyidle ready held low", 32'(sawEarly), 32'h0);
      @(posedge clk);
      #1;
      forceBusy = 1'b0;
      @(negedge clk);
      checkOutput("busyidle release ready", 32'(req_ready), 32'h4);
      sb.push_back('{2'd2, 8'h99, cyc});
      applyStimulus(4'b0, 32'h0);
      waitIdle("busyidle idle");

      modelEn = 1'b0;
      doReset();
      applyStimulus(4'b0010, 32'h00005A00);
      acceptExpected("timeout accept", 4'b0010, 2'd1, 8'h5A, t0);
      toCount = 0;
      toFirst = -1;
      nextReady = -1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (timeout_err) begin
            toCount++;
            if (toFirst < 0) toFirst = cyc;
         end
         if (req_ready != 4'b0 && nextReady < 0) begin
            nextReady = cyc;
            sb.push_back('{2'd1, 8'h5A, cyc});
         end
      end
      checkOutput("timeout pulse count", 32'(toCount), 32'h1);
      checkOutput("timeout pulse cycle", 32'(toFirst), 32'(t0 + 1 + START_TIMEOUT));
      checkOutput("timeout next grant", 32'(nextReady), 32'(t0 + 2 + START_TIMEOUT + GAP_CYCLES));
      applyStimulus(4'b0, 32'h0);
      doReset();
      modelEn = 1'b1;
      repeat (3) @(negedge clk);

      checkOutput("scoreboard drained", 32'(sb.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
